mips_run_monitor: RTL and testbench

Synthesizable run monitor for the single-cycle MIPS core, replacing ad-hoc bench polling of V0/A0. It watches per-cycle retire information and the V0/A0 registers, detects the exit syscall convention (V0 == exit code), captures A0 as the program result, enforces a cycle-budget watchdog, and keeps a circular trace of the last N retired instructions for post-mortem readout. It sits beside the `MIPS` top and is wired from its PC, instruction and register-bank taps.

---
 rtl/mips_mon_pkg.sv | 22 ++
 rtl/mips_trace_ring.sv | 64 ++++++
 rtl/mips_run_monitor.sv | 103 ++++++++++
 tb/tb_mips_run_monitor.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mips_mon_pkg.sv
// Shared types and default constants for the MIPS run monitor.
// The trace ring is built only when MIPS_MON_TRACE_EN is defined.
package mips_mon_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_DONE    = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  localparam int MON_EXIT_CODE   = 10;
  localparam int MON_TIMEOUT     = 200;
  localparam int MON_TRACE_DEPTH = 16;

  // Trace entry layout at the default 32-bit PC width.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/mips_trace_ring.sv
// Circular trace of retired {pc, instr}: overwrite-oldest when full,
// pop returns the oldest entry one cycle later as a single-cycle pulse.
module mips_trace_ring #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [PC_W-1:0]          wr_pc,
  input  logic [31:0]              wr_instr,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [PC_W-1:0]          rd_pc,
  output logic [31:0]              rd_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            pop;

  assign full = (count == CW'(DEPTH));
  assign pop  = rd_en && (count != '0);

  always_ff @(posedge clock) begin
    if (wr_en) begin
      pc_mem[wr_ptr]    <= wr_pc;
      instr_mem[wr_ptr] <= wr_instr;
    end
  end

  // Writes happen only in RUN and pops only after it, so the two never overlap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      rd_pc    <= '0;
      rd_instr <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (full) rd_ptr <= rd_ptr + 1'b1;
        else      count  <= count + 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b1;
        rd_pc    <= pc_mem[rd_ptr];
        rd_instr <= instr_mem[rd_ptr];
        rd_ptr   <= rd_ptr + 1'b1;
        count    <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mips_run_monitor.sv
// Run monitor for the single-cycle MIPS core: exit detection, result capture,
// cycle watchdog and optional retire trace (define MIPS_MON_TRACE_EN).
module mips_run_monitor
  import mips_mon_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                PC_W        = 32,
  parameter logic [DATA_W-1:0] EXIT_CODE   = DATA_W'(MON_EXIT_CODE),
  parameter logic [DATA_W-1:0] NOT_FOUND   = '1,
  parameter int                TIMEOUT     = MON_TIMEOUT,
  parameter int                TRACE_DEPTH = MON_TRACE_DEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         retire,
  input  logic [PC_W-1:0]              pc,
  input  logic [31:0]                  instr,
  input  logic [DATA_W-1:0]            v0,
  input  logic [DATA_W-1:0]            a0,
  output logic [1:0]                   state,
  output logic                         done,
  output logic                         timed_out,
  output logic [DATA_W-1:0]            result,
  output logic                         not_found,
  output logic [31:0]                  cycles,
  output logic [31:0]                  retired,
  input  logic                         trace_rd,
  output logic                         trace_valid,
  output logic [PC_W-1:0]              trace_pc,
  output logic [31:0]                  trace_instr,
  output logic [$clog2(TRACE_DEPTH):0] trace_count
);

  localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT - 1);

  state_t state_q;
  logic   in_run;
  logic   in_end;

  assign state  = state_q;
  assign in_run = (state_q == S_RUN);
  assign in_end = (state_q == S_DONE) || (state_q == S_TIMEOUT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      done      <= 1'b0;
      timed_out <= 1'b0;
      result    <= '0;
      not_found <= 1'b0;
      cycles    <= '0;
      retired   <= '0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_RUN;
        S_RUN: begin
          if (cycles != '1) cycles <= cycles + 1'b1;
          if (retire && retired != '1) retired <= retired + 1'b1;
          // Exit takes priority over a watchdog expiry on the same edge.
          if (v0 == EXIT_CODE) begin
            state_q   <= S_DONE;
            done      <= 1'b1;
            result    <= a0;
            not_found <= (a0 == NOT_FOUND);
          end else if (cycles == LAST_CYCLE) begin
            state_q   <= S_TIMEOUT;
            timed_out <= 1'b1;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

`ifdef MIPS_MON_TRACE_EN
  logic unused_end;
  assign unused_end = in_end;

  mips_trace_ring #(
    .PC_W  (PC_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (in_run && retire),
    .wr_pc    (pc),
    .wr_instr (instr),
    .rd_en    (in_end && trace_rd),
    .rd_valid (trace_valid),
    .rd_pc    (trace_pc),
    .rd_instr (trace_instr),
    .count    (trace_count)
  );
`else
  logic unused_trace;
  assign unused_trace = ^{trace_rd, pc, instr, in_end};
  assign trace_valid  = 1'b0;
  assign trace_pc     = '0;
  assign trace_instr  = '0;
  assign trace_count  = '0;
`endif

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench for mips_run_monitor: exit, not-found, watchdog, exit/timeout
// race, trace readout (when MIPS_MON_TRACE_EN is defined) and mid-readout reset.
module tb_mips_run_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        retire;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] v0;
  logic [31:0] a0;
  logic [1:0]  state;
  logic        done;
  logic        timed_out;
  logic [31:0] result;
  logic        not_found;
  logic [31:0] cycles;
  logic [31:0] retired;
  logic        trace_rd;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_instr;
  logic [4:0]  trace_count;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mips_run_monitor dut (
    .clock       (clock),
    .reset       (reset),
    .retire      (retire),
    .pc          (pc),
    .instr       (instr),
    .v0          (v0),
    .a0          (a0),
    .state       (state),
    .done        (done),
    .timed_out   (timed_out),
    .result      (result),
    .not_found   (not_found),
    .cycles      (cycles),
    .retired     (retired),
    .trace_rd    (trace_rd),
    .trace_valid (trace_valid),
    .trace_pc    (trace_pc),
    .trace_instr (trace_instr),
    .trace_count (trace_count)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Leaves the DUT just after the IDLE->RUN edge, with zero RUN edges taken.
  task automatic start_run();
    reset = 1'b1; retire = 1'b0; pc = '0; instr = '0;
    v0 = '0; a0 = '0; trace_rd = 1'b0;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; retire = 1'b0; pc = '0; instr = '0;
    v0 = '0; a0 = '0; trace_rd = 1'b0;
    step();
    tests++; if (state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d exp 0", state); end
    tests++; if ({done, timed_out, not_found} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b exp 000", {done, timed_out, not_found}); end
    tests++; if ({result, cycles, retired} !== 96'd0) begin fails++; $display("FAIL reset_counters got %h exp 0", {result, cycles, retired}); end
    tests++; if ({trace_valid, trace_count} !== 6'd0) begin fails++; $display("FAIL reset_trace got %h exp 0", {trace_valid, trace_count}); end
    reset = 1'b0;
    step();
    tests++; if (state !== 2'd1 || cycles !== 32'd0) begin fails++; $display("FAIL idle_to_run got state %0d cycles %0d exp 1 0", state, cycles); end
  endtask

  task automatic test_exit();
    start_run();
    retire = 1'b1;
    repeat (4) step();
    tests++; if (state !== 2'd1 || done !== 1'b0) begin fails++; $display("FAIL exit_premature got state %0d done %b exp 1 0", state, done); end
    v0 = 32'd10; a0 = 32'd3;
    step();
    tests++; if (state !== 2'd2 || done !== 1'b1 || timed_out !== 1'b0) begin fails++; $display("FAIL exit_state got %0d/%b/%b exp 2/1/0", state, done, timed_out); end
    tests++; if (result !== 32'd3 || not_found !== 1'b0) begin fails++; $display("FAIL exit_result got %0d nf %b exp 3 0", result, not_found); end
    tests++; if (cycles !== 32'd5 || retired !== 32'd5) begin fails++; $display("FAIL exit_counts got %0d %0d exp 5 5", cycles, retired); end
    a0 = 32'd99; v0 = 32'd0;
    repeat (3) step();
    tests++; if (cycles !== 32'd5 || retired !== 32'd5 || result !== 32'd3 || state !== 2'd2) begin fails++; $display("FAIL done_frozen got c %0d r %0d res %0d st %0d exp 5 5 3 2", cycles, retired, result, state); end
    retire = 1'b0;
  endtask

  task automatic test_not_found();
    start_run();
    v0 = 32'd10; a0 = 32'hFFFF_FFFF;
    step();
    tests++; if (done !== 1'b1 || not_found !== 1'b1) begin fails++; $display("FAIL nf_flags got done %b nf %b exp 1 1", done, not_found); end
    tests++; if (result !== 32'hFFFF_FFFF || cycles !== 32'd1) begin fails++; $display("FAIL nf_result got %h cycles %0d exp ffffffff 1", result, cycles); end
  endtask

  task automatic test_timeout();
    start_run();
    repeat (199) step();
    tests++; if (state !== 2'd1 || cycles !== 32'd199 || timed_out !== 1'b0) begin fails++; $display("FAIL to_early got st %0d c %0d to %b exp 1 199 0", state, cycles, timed_out); end
    step();
    tests++; if (state !== 2'd3 || timed_out !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL to_state got %0d/%b/%b exp 3/1/0", state, timed_out, done); end
    tests++; if (cycles !== 32'd200 || result !== 32'd0) begin fails++; $display("FAIL to_counts got c %0d res %0d exp 200 0", cycles, result); end
    v0 = 32'd10; a0 = 32'd5;
    step();
    tests++; if (state !== 2'd3 || done !== 1'b0 || result !== 32'd0 || cycles !== 32'd200) begin fails++; $display("FAIL to_frozen got st %0d done %b res %0d c %0d exp 3 0 0 200", state, done, result, cycles); end
  endtask

  task automatic test_exit_vs_timeout();
    start_run();
    repeat (199) step();
    v0 = 32'd10; a0 = 32'd7;
    step();
    tests++; if (state !== 2'd2 || done !== 1'b1 || timed_out !== 1'b0) begin fails++; $display("FAIL race_state got %0d/%b/%b exp 2/1/0", state, done, timed_out); end
    tests++; if (result !== 32'd7 || cycles !== 32'd200) begin fails++; $display("FAIL race_result got res %0d c %0d exp 7 200", result, cycles); end
  endtask

  task automatic test_trace_readout();
    start_run();
    trace_rd = 1'b1;  // must be ignored while running
    for (int i = 0; i < 20; i++) begin
      retire = 1'b1; pc = 32'(4 * i); instr = 32'hAB00_0000 | 32'(i);
      step();
      tests++; if (trace_valid !== 1'b0) begin fails++; $display("FAIL run_pop_ignored i %0d got %b exp 0", i, trace_valid); end
    end
    trace_rd = 1'b0; retire = 1'b0; v0 = 32'd10;
    step();
    tests++; if (state !== 2'd2 || retired !== 32'd20 || cycles !== 32'd21) begin fails++; $display("FAIL tr_exit got st %0d r %0d c %0d exp 2 20 21", state, retired, cycles); end
`ifdef MIPS_MON_TRACE_EN
    tests++; if (trace_count !== 5'd16) begin fails++; $display("FAIL tr_full_count got %0d exp 16", trace_count); end
    trace_rd = 1'b1;
    for (int j = 0; j < 16; j++) begin
      step();
      tests++; if (trace_valid !== 1'b1 || trace_pc !== 32'(16 + 4 * j) || trace_instr !== (32'hAB00_0000 | 32'(j + 4))) begin
        fails++; $display("FAIL tr_pop %0d got v %b pc %0d instr %h exp 1 %0d %h", j, trace_valid, trace_pc, trace_instr, 16 + 4 * j, 32'hAB00_0000 | 32'(j + 4));
      end
      tests++; if (trace_count !== 5'(15 - j)) begin fails++; $display("FAIL tr_count %0d got %0d exp %0d", j, trace_count, 15 - j); end
    end
    step();
    tests++; if (trace_valid !== 1'b0 || trace_count !== 5'd0) begin fails++; $display("FAIL tr_empty_pop got v %b cnt %0d exp 0 0", trace_valid, trace_count); end
    trace_rd = 1'b0;
`else
    trace_rd = 1'b1;
    repeat (3) step();
    tests++; if (trace_valid !== 1'b0 || trace_count !== 5'd0 || trace_pc !== 32'd0 || trace_instr !== 32'd0) begin fails++; $display("FAIL tr_disabled got v %b cnt %0d pc %0d instr %h exp 0 0 0 0", trace_valid, trace_count, trace_pc, trace_instr); end
    trace_rd = 1'b0;
`endif
  endtask

  task automatic test_reset_mid_readout();
    start_run();
    for (int i = 0; i < 10; i++) begin
      retire = 1'b1; pc = 32'(100 + 4 * i); instr = 32'(i);
      step();
    end
    retire = 1'b0; v0 = 32'd10; a0 = 32'd42;
    step();
    trace_rd = 1'b1;
    step();
    step();
`ifdef MIPS_MON_TRACE_EN
    tests++; if (trace_count !== 5'd8 || trace_pc !== 32'd104) begin fails++; $display("FAIL mid_pre got cnt %0d pc %0d exp 8 104", trace_count, trace_pc); end
`endif
    #2 reset = 1'b1;
    #1;
    tests++; if (state !== 2'd0 || {done, timed_out, not_found} !== 3'b000) begin fails++; $display("FAIL mid_reset_state got st %0d flags %b exp 0 000", state, {done, timed_out, not_found}); end
    tests++; if ({result, cycles, retired} !== 96'd0) begin fails++; $display("FAIL mid_reset_counts got %h exp 0", {result, cycles, retired}); end
    tests++; if ({trace_valid, trace_count, trace_pc, trace_instr} !== 70'd0) begin fails++; $display("FAIL mid_reset_trace got %h exp 0", {trace_valid, trace_count, trace_pc, trace_instr}); end
    trace_rd = 1'b0; v0 = '0; a0 = '0;
    step();
    reset = 1'b0;
    step();
    tests++; if (state !== 2'd1 || cycles !== 32'd0 || trace_count !== 5'd0) begin fails++; $display("FAIL mid_rerun got st %0d c %0d cnt %0d exp 1 0 0", state, cycles, trace_count); end
  endtask

  initial begin
    test_reset();
    test_exit();
    test_not_found();
    test_timeout();
    test_exit_vs_timeout();
    test_trace_readout();
    test_reset_mid_readout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
